// File: rtl/stack_cache_spill_fill_if.sv
// stack_cache_spill_fill_if: word-serial memory request/response bus between the line engine and memory
interface stack_cache_spill_fill_if #(
  parameter int DATABITWIDTH = 32,
  parameter int ADDRESS_BITWIDTH = 32
);
  logic MemReqValid;
  logic MemReqReady;
  logic MemReqWrite;
  logic [ADDRESS_BITWIDTH-1:0] MemReqAddress;
  logic [DATABITWIDTH-1:0] MemReqData;
  logic MemRespValid;
  logic [DATABITWIDTH-1:0] MemRespData;
  modport master (
    output MemReqValid, MemReqWrite, MemReqAddress, MemReqData,
    input MemReqReady, MemRespValid, MemRespData
  );
  modport slave (
    input MemReqValid, MemReqWrite, MemReqAddress, MemReqData,
    output MemReqReady, MemRespValid, MemRespData
  );
endinterface

// File: rtl/stack_cache_spill_fill.sv
// stack_cache_spill_fill: moves one stack-cache line to memory (spill) or from memory into the array (fill)
module stack_cache_spill_fill #(
  parameter int LINESIZE = 8,
  parameter int DATABITWIDTH = 32,
  parameter int ADDRESS_BITWIDTH = 32,
  localparam int LINEADDRBITWIDTH = $clog2(LINESIZE)
) (
  input  logic clk,
  input  logic async_rst_n,
  input  logic clk_en,
  input  logic SpillRequest,
  input  logic FillRequest,
  input  logic [ADDRESS_BITWIDTH-1:0] LineAddress,
  output logic RequestReady,
  output logic Busy,
  output logic Done,
  output logic CacheReadEn,
  output logic [LINEADDRBITWIDTH-1:0] CacheReadIndex,
  input  logic [DATABITWIDTH-1:0] CacheReadData,
  output logic CacheWriteEn,
  output logic [LINEADDRBITWIDTH-1:0] CacheWriteIndex,
  output logic [DATABITWIDTH-1:0] CacheWriteData,
  stack_cache_spill_fill_if.master mem
);
  localparam int W = LINEADDRBITWIDTH;
  localparam logic [W:0] LAST = (W+1)'(LINESIZE - 1);
  typedef enum logic [2:0] {IDLE, SPILL_LOAD, SPILL_SEND, FILL_ISSUE, FILL_DRAIN, DONE} state_t;
  state_t state, nextState;
  logic [W:0] issueCount, respCount;
  logic [ADDRESS_BITWIDTH-W-1:0] baseUpper;
  logic [DATABITWIDTH-1:0] lineBuffer [LINESIZE];
  logic accept, reqFire, respFire, respDone, loadCapture, unusedLineOffset;
  assign unusedLineOffset = ^LineAddress[W-1:0];
  assign accept = (SpillRequest || FillRequest) && RequestReady && clk_en;
  assign reqFire = mem.MemReqValid && mem.MemReqReady;
  assign respFire = (state == FILL_ISSUE || state == FILL_DRAIN) && mem.MemRespValid;
  assign respDone = respCount[W] || (respFire && respCount == LAST);
  // a read issued last cycle is outstanding whenever captures lag reads
  assign loadCapture = state == SPILL_LOAD && respCount != issueCount;
  assign RequestReady = state == IDLE;
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  assign CacheReadEn = state == SPILL_LOAD && !issueCount[W];
  assign CacheReadIndex = issueCount[W-1:0];
  assign CacheWriteEn = respFire;
  assign CacheWriteIndex = respCount[W-1:0];
  assign CacheWriteData = respFire ? mem.MemRespData : '0;
  assign mem.MemReqValid = state == SPILL_SEND || state == FILL_ISSUE;
  assign mem.MemReqWrite = state == SPILL_SEND;
  assign mem.MemReqAddress = {baseUpper, issueCount[W-1:0]};
  assign mem.MemReqData = lineBuffer[issueCount[W-1:0]];
  always_comb begin
    nextState = state;
    case (state)
      IDLE:       nextState = !accept ? IDLE : SpillRequest ? SPILL_LOAD : FILL_ISSUE;
      SPILL_LOAD: nextState = issueCount[W] && respCount == LAST ? SPILL_SEND : SPILL_LOAD;
      SPILL_SEND: nextState = reqFire && issueCount == LAST ? DONE : SPILL_SEND;
      FILL_ISSUE: nextState = !(reqFire && issueCount == LAST) ? FILL_ISSUE : respDone ? DONE : FILL_DRAIN;
      FILL_DRAIN: nextState = respDone ? DONE : FILL_DRAIN;
      DONE:       nextState = IDLE;
      default:    nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state <= IDLE;
      issueCount <= '0;
      respCount <= '0;
      baseUpper <= '0;
    end else if (clk_en) begin
      state <= nextState;
      if (accept) begin
        issueCount <= '0;
        respCount <= '0;
        baseUpper <= LineAddress[ADDRESS_BITWIDTH-1:W];
      end else if (state == SPILL_LOAD && nextState == SPILL_SEND) begin
        issueCount <= '0;
      end else begin
        if (CacheReadEn || reqFire) issueCount <= issueCount + 1'b1;
        if (loadCapture || respFire) respCount <= respCount + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) lineBuffer <= '{default: '0};
    else if (clk_en && loadCapture) lineBuffer[respCount[W-1:0]] <= CacheReadData;
  end
endmodule

// File: tb/tb_stack_cache_spill_fill.sv
// tb_stack_cache_spill_fill: scoreboard bench with a reactive memory and array model
module tb_stack_cache_spill_fill;
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} req_t;
  typedef struct packed {logic [2:0] i; logic [31:0] d;} wr_t;
  logic clk, async_rst_n, clk_en, SpillRequest, FillRequest;
  logic [31:0] LineAddress, CacheReadData, CacheWriteData;
  logic RequestReady, Busy, Done, CacheReadEn, CacheWriteEn;
  logic [2:0] CacheReadIndex, CacheWriteIndex;
  stack_cache_spill_fill_if #(.DATABITWIDTH(32), .ADDRESS_BITWIDTH(32)) bus();
  stack_cache_spill_fill dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .SpillRequest(SpillRequest), .FillRequest(FillRequest), .LineAddress(LineAddress),
    .RequestReady(RequestReady), .Busy(Busy), .Done(Done),
    .CacheReadEn(CacheReadEn), .CacheReadIndex(CacheReadIndex), .CacheReadData(CacheReadData),
    .CacheWriteEn(CacheWriteEn), .CacheWriteIndex(CacheWriteIndex), .CacheWriteData(CacheWriteData),
    .mem(bus)
  );
  int tests = 0, fails = 0, cycT = 0, issuedReads = 0;
  logic stallMode = 0, holdResp = 0;
  logic [31:0] cacheArr [8];
  req_t expReq[$];
  wr_t expWr[$];
  logic [31:0] respQ[$];
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  // array: registered read, frozen with the rest of the domain when clk_en is low
  initial begin
    logic rdEn;
    logic [2:0] rdIdx;
    forever begin
      @(negedge clk);
      rdEn = CacheReadEn && clk_en && async_rst_n;
      rdIdx = CacheReadIndex;
      @(posedge clk);
      #1;
      if (rdEn) CacheReadData = cacheArr[rdIdx];
    end
  end
  // memory responder plus scoreboard monitor
  initial begin
    req_t e, prevVal;
    wr_t ew;
    logic prevStall;
    prevStall = 0;
    prevVal = '0;
    forever begin
      @(negedge clk);
      bus.MemRespValid = 0;
      bus.MemRespData = 0;
      if (respQ.size() > 0 && (!holdResp || issuedReads >= 8)) begin
        bus.MemRespValid = 1;
        bus.MemRespData = respQ.pop_front();
      end
      bus.MemReqReady = stallMode ? !bus.MemReqReady : 1'b1;
      if (async_rst_n && bus.MemReqValid && bus.MemReqReady && !bus.MemReqWrite) begin
        respQ.push_back(32'hB0 + {29'd0, bus.MemReqAddress[2:0]});
        issuedReads++;
      end
      #1;
      if (bus.MemReqValid && bus.MemReqReady) begin
        if (expReq.size() == 0) begin
          tests++; fails++;
          $display("FAIL memreq_unexpected: got addr %0h expected none", bus.MemReqAddress);
        end else begin
          e = expReq.pop_front();
          check("memreq_kind_addr", {bus.MemReqWrite, bus.MemReqAddress}, {e.w, e.a});
          if (e.w) check("memreq_data", bus.MemReqData, e.d);
        end
      end
      if (prevStall && bus.MemReqValid)
        check("memreq_hold", {bus.MemReqWrite, bus.MemReqAddress, bus.MemReqData}, prevVal);
      prevStall = async_rst_n && bus.MemReqValid && !bus.MemReqReady;
      prevVal = {bus.MemReqWrite, bus.MemReqAddress, bus.MemReqData};
      if (CacheWriteEn) begin
        if (expWr.size() == 0) begin
          tests++; fails++;
          $display("FAIL cachewr_unexpected: got idx %0d expected none", CacheWriteIndex);
        end else begin
          ew = expWr.pop_front();
          check("cachewr", {CacheWriteIndex, CacheWriteData}, {ew.i, ew.d});
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    cycT++;
  endtask
  task automatic pushSpill(input logic [31:0] base, input logic [31:0] dataBase);
    for (int i = 0; i < 8; i++) begin
      cacheArr[i] = dataBase + i;
      expReq.push_back('{1'b1, base + i, dataBase + i});
    end
  endtask
  task automatic pushFill(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      expReq.push_back('{1'b0, base + i, 32'd0});
      expWr.push_back('{3'(i), 32'hB0 + i});
    end
  endtask
  task automatic request(input logic spill, input logic fill, input logic [31:0] addr);
    tick();
    SpillRequest = spill;
    FillRequest = fill;
    LineAddress = addr;
    cycT = 0;
    tick();
    SpillRequest = 0;
    FillRequest = 0;
  endtask
  task automatic waitDone(input string name, input int expLat);
    while (!Done && cycT < 300) tick();
    check({name, "_done_seen"}, Done, 1'b1);
    if (expLat >= 0) check({name, "_latency"}, cycT, expLat);
    tick();
    check({name, "_done_once"}, {Done, RequestReady}, 2'b01);
  endtask
  initial begin
    logic [2:0] held;
    async_rst_n = 0; clk_en = 1; SpillRequest = 0; FillRequest = 0; LineAddress = 0;
    CacheReadData = 0;
    bus.MemReqReady = 1; bus.MemRespValid = 0; bus.MemRespData = 0;
    for (int i = 0; i < 8; i++) cacheArr[i] = 0;
    repeat (3) tick();
    check("reset_ready_busy_done", {RequestReady, Busy, Done}, 3'b100);
    async_rst_n = 1;
    tick();
    check("idle_strobes", {CacheReadEn, CacheWriteEn, bus.MemReqValid, bus.MemReqWrite}, 4'b0000);
    check("idle_indices", {CacheReadIndex, CacheWriteIndex}, 6'd0);
    check("idle_addr_data", {bus.MemReqAddress, bus.MemReqData, CacheWriteData}, 96'd0);
    check("idle_ready", {RequestReady, Busy}, 2'b10);
    pushSpill(32'h1000, 32'hA0);
    request(1, 0, 32'h1005);
    waitDone("spill", 18);
    pushSpill(32'h3000, 32'hC0);
    request(1, 1, 32'h3003);
    waitDone("both_spill", 18);
    pushFill(32'h3000);
    request(0, 1, 32'h3003);
    waitDone("fill", 10);
    stallMode = 1;
    pushFill(32'h2FF8);
    request(0, 1, 32'h2FFF);
    waitDone("fill_stall", -1);
    stallMode = 0;
    holdResp = 1;
    issuedReads = 0;
    pushFill(32'h4000);
    request(0, 1, 32'h4002);
    while (cycT < 10) tick();
    check("drain_busy_nodone", {Busy, Done}, 2'b10);
    waitDone("fill_drain", 17);
    holdResp = 0;
    pushSpill(32'h5000, 32'hA0);
    request(1, 0, 32'h5001);
    while (cycT < 4) tick();
    clk_en = 0;
    held = CacheReadIndex;
    check("freeze_index_value", held, 3'd3);
    tick();
    check("freeze_index_1", CacheReadIndex, held);
    tick();
    check("freeze_index_2", CacheReadIndex, held);
    tick();
    clk_en = 1;
    waitDone("spill_freeze", 21);
    check("expreq_drained", expReq.size(), 0);
    check("expwr_drained", expWr.size(), 0);
    pushSpill(32'h1000, 32'hA0);
    request(1, 0, 32'h1005);
    while (cycT < 13) tick();
    check("mid_send_active", {bus.MemReqValid, bus.MemReqWrite}, 2'b11);
    #2;
    async_rst_n = 0;
    #1;
    check("reset_abort_now", {bus.MemReqValid, Busy, RequestReady}, 3'b001);
    expReq.delete();
    tick();
    async_rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_abort_quiet", {Done, bus.MemReqValid, CacheReadEn, RequestReady}, 4'b0001);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stack_cache_spill_fill.md
# stack_cache_spill_fill

Line-transfer engine on the memory side of the stack cache. It consumes the spill (push-out) and fill (pop-in) line requests raised by the stack pointer tracker. A spill copies one cache line word-by-word from the stack cache array to memory. A fill copies one line from memory into the array. It owns the word-serial memory request/response handshake and reports completion back to the stack cache control.

## Interface
Parameters:
- LINESIZE, 8, words per cache line (power of two, ≥2); LINEADDRBITWIDTH = $clog2(LINESIZE)
- DATABITWIDTH, 32, word width
- ADDRESS_BITWIDTH, 32, word address width

Ports:
- clk  in  1  clock; one clock domain
- async_rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  global clock enable; when low, all state is frozen
- SpillRequest  in  1  request to write a line out to memory
- FillRequest  in  1  request to read a line in from memory
- LineAddress  in  ADDRESS_BITWIDTH  any word address inside the target line
- RequestReady  out  1  high only in IDLE
- Busy  out  1  high in any non-IDLE state
- Done  out  1  one-cycle pulse when a transfer completes
- CacheReadEn  out  1  array read strobe; data returns 1 cycle later
- CacheReadIndex  out  LINEADDRBITWIDTH  word index within the line
- CacheReadData  in  DATABITWIDTH  array read data
- CacheWriteEn  out  1  array write strobe
- CacheWriteIndex  out  LINEADDRBITWIDTH  word index within the line
- CacheWriteData  out  DATABITWIDTH  array write data
- MemReqValid  out  1  memory request valid
- MemReqReady  in  1  memory accepts the request
- MemReqWrite  out  1  1 = write, 0 = read
- MemReqAddress  out  ADDRESS_BITWIDTH  word address
- MemReqData  out  DATABITWIDTH  write data
- MemRespValid  in  1  read response valid; responses return in order
- MemRespData  in  DATABITWIDTH  read response data

## Operation
- Base address = {LineAddress[ADDRESS_BITWIDTH-1:LINEADDRBITWIDTH], zeros}. Latch it at acceptance. Word i uses address base+i, i = 0..LINESIZE-1, in ascending order.
- A request is accepted when (SpillRequest || FillRequest) && RequestReady && clk_en.
- If both requests are asserted in the same cycle, the spill is accepted. The requester must re-present the fill.
- States:
  - IDLE → SPILL_LOAD on spill acceptance; → FILL_ISSUE on fill acceptance.
  - SPILL_LOAD:
    - CacheReadEn is high for LINESIZE consecutive cycles, with CacheReadIndex = 0..LINESIZE-1.
    - Each returned word is captured into an internal LINESIZE-word line buffer one cycle after its read.
    - Exit → SPILL_SEND in the cycle after the last capture.
  - SPILL_SEND:
    - MemReqValid=1, MemReqWrite=1, MemReqAddress=base+i, MemReqData=buffer[i].
    - Address and data hold stable until MemReqReady.
    - i advances on each handshake. After handshake LINESIZE-1 → DONE.
  - FILL_ISSUE:
    - MemReqValid=1, MemReqWrite=0, MemReqAddress=base+i.
    - i advances on each handshake. After LINESIZE handshakes → FILL_DRAIN, unless all responses have already arrived, in which case → DONE.
  - FILL_DRAIN: waits until the response count reaches LINESIZE, then → DONE.
  - Fill responses (in FILL_ISSUE or FILL_DRAIN):
    - Each MemRespValid causes, in the same cycle, CacheWriteEn=1, CacheWriteIndex=response count, CacheWriteData=MemRespData.
    - Responses may overlap with issue.
  - DONE: Done=1 for exactly one cycle, then → IDLE.
- MemRespValid is ignored outside the fill states.
- Issue and response counters are LINEADDRBITWIDTH+1 bits wide, cleared on acceptance, and never wrap within a transfer.
- Base address arithmetic: base+i never carries past bit LINEADDRBITWIDTH-1, so the upper bits are passed through unchanged.
- clk_en low: the FSM, counters and buffer hold, and outputs hold their values. The memory side must not assert MemRespValid while clk_en is low.

## Timing
- Reset values:
  - RequestReady=1, Busy=0, Done=0.
  - CacheReadEn=0, CacheWriteEn=0, MemReqValid=0, MemReqWrite=0.
  - All index, address and data outputs are 0; FSM is in IDLE.
- Reset asserted mid-transfer aborts immediately. No further requests or writes are issued, and no Done pulse is produced.
- Spill latency, with acceptance at cycle T and MemReqReady tied high:
  - Reads occur at T+1..T+LINESIZE.
  - Writes occur at T+LINESIZE+2..T+2·LINESIZE+1.
  - Done is high at T+2·LINESIZE+2.
- Fill latency, with acceptance at T, MemReqReady tied high and 1-cycle memory latency:
  - Requests issue at T+1..T+LINESIZE.
  - Cache writes occur at T+2..T+LINESIZE+1.
  - Done is high at T+LINESIZE+2.
- RequestReady returns high in the cycle after Done, which allows back-to-back transfers.

## Test plan
- Reset then idle: after async_rst_n is released, RequestReady=1 and all strobes are 0. Asserting reset mid-SPILL_SEND forces MemReqValid=0 in the same cycle.
- Spill, LINESIZE=8, LineAddress=0x1005:
  - Array words are 0xA0..0xA7.
  - Expect memory writes 0x1000..0x1007 with data 0xA0..0xA7.
  - Expect Done at T+18.
- Fill with MemReqReady stalls (low every other cycle) at LineAddress=0x2FFF:
  - Expect reads 0x2FF8..0x2FFF, each held stable until its handshake.
  - Responses 0xB0..0xB7 are written to array indices 0..7.
- Simultaneous SpillRequest and FillRequest: the spill is accepted (MemReqWrite=1 in its send phase). The re-presented fill completes afterward.
- Fill with all responses delayed until after the last issue: FILL_DRAIN is held, Busy=1 and Done stays low until the 8th response arrives, then Done pulses once.
- clk_en low for 3 cycles mid-SPILL_LOAD: CacheReadIndex is frozen. The resulting memory data is still 0xA0..0xA7 in order.
